// File: rtl/vga_overlay_pkg.sv
// Shared types, widths and arithmetic helpers for the VGA overlay blocks.
package vga_overlay_pkg;

  localparam int COLOR_W = 12;
  localparam int COORD_W = 10;
  localparam int STICK_W = 8;

  localparam logic [COLOR_W-1:0] KEY_COLOR_DEFAULT    = 12'h000;
  localparam logic [COLOR_W-1:0] CENTER_COLOR_DEFAULT = 12'h888;
  localparam logic [STICK_W-1:0] STICK_CENTER_DEFAULT = 8'd128;

  typedef enum logic [1:0] {
    CAL_IDLE  = 2'd0,
    CAL_ACCUM = 2'd1,
    CAL_APPLY = 2'd2
  } cal_state_t;

  // Screen offset for a raw reading: 3/8 of the deflection, zero inside the deadzone.
  function automatic logic [COORD_W-1:0] stick_offset(input logic [STICK_W-1:0] raw,
                                                      input logic [STICK_W-1:0] center,
                                                      input int deadzone);
    logic [STICK_W-1:0] d;
    d = (raw >= center) ? raw - center : center - raw;
    if (int'(d) <= deadzone) return '0;
    return COORD_W'(d >> 2) + COORD_W'(d >> 3);
  endfunction

  // Addition clamped to the highest legal sprite edge.
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b,
                                                 input logic [COORD_W:0]   limit);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > limit) ? limit[COORD_W-1:0] : s[COORD_W-1:0];
  endfunction

  // Subtraction clamped at the screen edge instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

endpackage

// File: rtl/stick_channel.sv
// One analog-stick sprite: center register, offset arithmetic, per-frame
// position latch, hit test, ROM addressing and the hit alignment stage.
module stick_channel
  import vga_overlay_pkg::*;
#(
  parameter int                 SPRITE_SIZE  = 70,
  parameter logic [COORD_W-1:0] ORIGIN_X     = 10'd64,
  parameter logic [COORD_W-1:0] ORIGIN_Y     = 10'd223,
  parameter int                 DEADZONE     = 3,
  parameter logic [COLOR_W-1:0] KEY_COLOR    = KEY_COLOR_DEFAULT,
  parameter logic [COLOR_W-1:0] CENTER_COLOR = CENTER_COLOR_DEFAULT,
  parameter bit                 CENTER_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_start,
  input  logic [STICK_W-1:0] raw_x,
  input  logic [STICK_W-1:0] raw_y,
  input  logic               center_load,
  input  logic [STICK_W-1:0] center_x_new,
  input  logic [STICK_W-1:0] center_y_new,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [COORD_W-1:0] rom_col,
  output logic [COORD_W-1:0] rom_row,
  output logic               drawn,
  output logic               center_hit
);

  localparam logic [COORD_W:0] POS_MAX  = (COORD_W+1)'(2**COORD_W - 1 - SPRITE_SIZE);
  localparam logic [COORD_W:0] SIZE_EXT = (COORD_W+1)'(SPRITE_SIZE);

  logic [STICK_W-1:0] center_x, center_y;
  logic [COORD_W-1:0] left, top;
  logic [COORD_W-1:0] off_x, off_y;
  logic               hit, hit_q;

  assign off_x = stick_offset(raw_x, center_x, DEADZONE);
  assign off_y = stick_offset(raw_y, center_y, DEADZONE);

  // Calibrated center, replaced only when the calibration result is applied.
  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // here the position latch below still sees the old center in the load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      center_x <= STICK_CENTER_DEFAULT;
      center_y <= STICK_CENTER_DEFAULT;
    end else if (center_load) begin
      center_x <= center_x_new;
      center_y <= center_y_new;
    end
  end

  // Sprite position, moved only at frame boundaries so a frame never tears.
  // Screen Y grows downward while raw Y grows upward, hence the swapped signs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left <= ORIGIN_X;
      top  <= ORIGIN_Y;
    end else if (frame_start) begin
      left <= (raw_x >= center_x) ? sat_add(ORIGIN_X, off_x, POS_MAX) : sat_sub(ORIGIN_X, off_x);
      top  <= (raw_y >= center_y) ? sat_sub(ORIGIN_Y, off_y) : sat_add(ORIGIN_Y, off_y, POS_MAX);
    end
  end

  assign rom_col = x - left;
  assign rom_row = y - top;

  assign hit = ({1'b0, left} < {1'b0, x}) && ({1'b0, x} < ({1'b0, left} + SIZE_EXT)) &&
               ({1'b0, top}  < {1'b0, y}) && ({1'b0, y} < ({1'b0, top}  + SIZE_EXT));

  // Delay the hit by one cycle so it lines up with the synchronous ROM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hit_q <= 1'b0;
    else        hit_q <= hit;
  end

  assign drawn      = hit_q && (rom_data != KEY_COLOR) && (rom_data != CENTER_COLOR);
  assign center_hit = CENTER_EN && hit_q && (rom_data == CENTER_COLOR);

endmodule

// File: rtl/stick_overlay_engine.sv
// Analog-stick overlay: per-stick sprite channels, multi-frame center
// calibration and the fixed-priority pixel mux feeding the top-level video mux.
module stick_overlay_engine
  import vga_overlay_pkg::*;
#(
  parameter int                            NUM_STICKS   = 2,
  parameter int                            SPRITE_SIZE  = 70,
  parameter logic [COORD_W*NUM_STICKS-1:0] ORIGIN_X     = {10'd221, 10'd64},
  parameter logic [COORD_W*NUM_STICKS-1:0] ORIGIN_Y     = {10'd232, 10'd223},
  parameter int                            DEADZONE     = 3,
  parameter int                            CAL_LOG2     = 3,
  parameter logic [COLOR_W-1:0]            KEY_COLOR    = KEY_COLOR_DEFAULT,
  parameter logic [COLOR_W-1:0]            CENTER_COLOR = CENTER_COLOR_DEFAULT,
  parameter logic [NUM_STICKS-1:0]         CENTER_MASK  = 2'b01
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [COORD_W-1:0]              x,
  input  logic [COORD_W-1:0]              y,
  input  logic                            frame_start,
  input  logic [STICK_W*NUM_STICKS-1:0]   stick_x,
  input  logic [STICK_W*NUM_STICKS-1:0]   stick_y,
  input  logic                            calibrate,
  output logic [COORD_W*NUM_STICKS-1:0]   rom_col,
  output logic [COORD_W*NUM_STICKS-1:0]   rom_row,
  input  logic [COLOR_W*NUM_STICKS-1:0]   rom_data,
  output logic                            overlay_on,
  output logic                            in_center,
  output logic [COLOR_W-1:0]              rgb,
  output logic                            cal_busy
);

  localparam int               SUM_W       = STICK_W + CAL_LOG2;
  localparam int               CNT_W       = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(2**CAL_LOG2 - 1);

  cal_state_t         state;
  logic [CNT_W-1:0]   sample_cnt;
  logic [SUM_W-1:0]   sum_x [NUM_STICKS];
  logic [SUM_W-1:0]   sum_y [NUM_STICKS];
  logic               center_load;
  logic [NUM_STICKS-1:0] drawn, center_hit;
  logic               overlay_d, in_center_d;
  logic [COLOR_W-1:0] rgb_d;

  assign center_load = (state == CAL_APPLY);

  for (genvar i = 0; i < NUM_STICKS; i++) begin : g_ch
    stick_channel #(
      .SPRITE_SIZE (SPRITE_SIZE),
      .ORIGIN_X    (ORIGIN_X[i*COORD_W +: COORD_W]),
      .ORIGIN_Y    (ORIGIN_Y[i*COORD_W +: COORD_W]),
      .DEADZONE    (DEADZONE),
      .KEY_COLOR   (KEY_COLOR),
      .CENTER_COLOR(CENTER_COLOR),
      .CENTER_EN   (CENTER_MASK[i])
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (x),
      .y           (y),
      .frame_start (frame_start),
      .raw_x       (stick_x[i*STICK_W +: STICK_W]),
      .raw_y       (stick_y[i*STICK_W +: STICK_W]),
      .center_load (center_load),
      .center_x_new(STICK_W'(sum_x[i] >> CAL_LOG2)),
      .center_y_new(STICK_W'(sum_y[i] >> CAL_LOG2)),
      .rom_data    (rom_data[i*COLOR_W +: COLOR_W]),
      .rom_col     (rom_col[i*COORD_W +: COORD_W]),
      .rom_row     (rom_row[i*COORD_W +: COORD_W]),
      .drawn       (drawn[i]),
      .center_hit  (center_hit[i])
    );
  end

  // Calibration: sum 2^CAL_LOG2 frame samples per axis, then load the averages.
  // A calibrate pulse only matters in IDLE; the start cycle never samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CAL_IDLE;
      cal_busy   <= 1'b0;
      sample_cnt <= '0;
      // NOTE: the accumulators are small register arrays, not RAM, so they are
      // reset like any other state to make an aborted calibration fully clean.
      for (int i = 0; i < NUM_STICKS; i++) begin
        sum_x[i] <= '0;
        sum_y[i] <= '0;
      end
    end else begin
      case (state)
        CAL_IDLE: begin
          if (calibrate) begin
            state      <= CAL_ACCUM;
            cal_busy   <= 1'b1;
            sample_cnt <= '0;
            for (int i = 0; i < NUM_STICKS; i++) begin
              sum_x[i] <= '0;
              sum_y[i] <= '0;
            end
          end
        end
        CAL_ACCUM: begin
          if (frame_start) begin
            for (int i = 0; i < NUM_STICKS; i++) begin
              sum_x[i] <= sum_x[i] + SUM_W'(stick_x[i*STICK_W +: STICK_W]);
              sum_y[i] <= sum_y[i] + SUM_W'(stick_y[i*STICK_W +: STICK_W]);
            end
            sample_cnt <= sample_cnt + 1'b1;
            if (sample_cnt == LAST_SAMPLE) state <= CAL_APPLY;
          end
        end
        CAL_APPLY: begin
          state    <= CAL_IDLE;
          cal_busy <= 1'b0;
        end
        default: begin
          state    <= CAL_IDLE;
          cal_busy <= 1'b0;
        end
      endcase
    end
  end

  // Priority mux: lowest index wins the colour; a center pixel is hidden
  // only by a drawn pixel of a higher-priority (lower-index) stick.
  always_comb begin
    logic blocked;
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    blocked     = 1'b0;
    overlay_d   = |drawn;
    in_center_d = 1'b0;
    rgb_d       = '0;
    for (int i = 0; i < NUM_STICKS; i++) begin
      if (center_hit[i] && !blocked) in_center_d = 1'b1;
      blocked = blocked | drawn[i];
    end
    for (int i = NUM_STICKS - 1; i >= 0; i--) begin
      if (drawn[i]) rgb_d = rom_data[i*COLOR_W +: COLOR_W];
    end
  end

  // Registered pixel outputs, two cycles after the x/y that produced them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overlay_on <= 1'b0;
      in_center  <= 1'b0;
      rgb        <= '0;
    end else begin
      overlay_on <= overlay_d;
      in_center  <= in_center_d;
      rgb        <= rgb_d;
    end
  end

endmodule
